imem_program_loader: RTL and testbench



---
 rtl/imem_program_loader_pkg.sv | 17 +
 rtl/imem_program_loader_byte_assembler.sv | 38 +++
 rtl/imem_program_loader.sv | 140 ++++++++++++++
 tb/tb_imem_program_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared types for the instruction-memory program loader: FSM encoding and framing constants.
// No logic here; imported by the loader top and its byte assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_program_loader_byte_assembler.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid pulses the cycle after the 4th byte.
// No backpressure of its own: every in_vld byte is consumed, clear drops any partial word.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [31:0] shift_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt   <= 2'd0;
      shift_q    <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      byte_cnt   <= 2'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= in_vld && (byte_cnt == 2'(BYTES_PER_WORD - 1));
      if (in_vld) begin
        shift_q  <= {shift_q[23:0], in_dat};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // The shift register holds the complete word throughout the word_valid cycle.
  assign word = shift_q;

endmodule

// File: rtl/imem_program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the CPU until complete.
// Write strobe one cycle after the 4th byte of a word; rx_ready stays high throughout a load.
module imem_program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             imem_we,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] length;
  logic [LEN_W-1:0] words_cnt;
  logic [TW-1:0]    idle_cnt;
  logic [31:0]      addr_q;

  logic             rx_fire;
  logic [LEN_W-1:0] len_word;
  logic             asm_in_vld;
  logic             asm_clear;
  logic [31:0]      asm_word;
  logic             asm_word_vld;
  logic             last_write;
  logic             timed_out;

  assign rx_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
  assign rx_fire  = rx_valid && rx_ready;
  assign busy     = rx_ready;
  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign cpu_hold = (state != DONE);

  assign len_word     = {len_hi, rx_data};
  assign words_loaded = words_cnt + LEN_W'(asm_word_vld);

  // Bytes arriving while the final word is being written belong to no word and are dropped.
  assign asm_in_vld = rx_fire && (state == DATA) && (words_loaded < length);
  assign asm_clear  = (state != DATA);
  assign last_write = asm_word_vld && (words_loaded == length);
  assign timed_out  = !rx_fire && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign imem_addr  = addr_q;
  assign imem_wdata = asm_word;
  assign imem_we    = asm_word_vld;

  byte_assembler u_asm (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (asm_clear),
    .in_vld     (asm_in_vld),
    .in_dat     (rx_data),
    .word       (asm_word),
    .word_valid (asm_word_vld)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      len_hi    <= 8'd0;
      length    <= '0;
      words_cnt <= '0;
      idle_cnt  <= '0;
      addr_q    <= BASE_ADDR;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= LEN_HI;
            length    <= '0;
            words_cnt <= '0;
            idle_cnt  <= '0;
            addr_q    <= BASE_ADDR;
          end
        end

        LEN_HI, LEN_LO, DATA: begin
          if (rx_fire) begin
            idle_cnt <= '0;
          end else if (!timed_out) begin
            idle_cnt <= idle_cnt + TW'(1);
          end

          if (state == LEN_HI) begin
            if (rx_fire) begin
              len_hi <= rx_data;
              state  <= LEN_LO;
            end else if (timed_out) begin
              state <= ERROR;
            end
          end else if (state == LEN_LO) begin
            if (rx_fire) begin
              length <= len_word;
              if (len_word == '0) begin
                state <= DONE;
              end else if ({16'd0, len_word} > MAX_WORDS) begin
                state <= ERROR;
              end else begin
                state <= DATA;
              end
            end else if (timed_out) begin
              state <= ERROR;
            end
          end else begin
            // Address advances at the end of each write cycle, so it always names the next slot.
            if (asm_word_vld) begin
              words_cnt <= words_cnt + LEN_W'(1);
              addr_q    <= addr_q + 32'(BYTES_PER_WORD);
            end
            if (last_write) begin
              state <= DONE;
            end else if (timed_out) begin
              state <= ERROR;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed and randomized program loads checked against a stream-level model of the expected writes.
module tb_imem_program_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;
  localparam int          TMO  = 16;

  typedef logic [7:0] byte_q_t[$];

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_cmp   = 0;
  int n_bad   = 0;
  int inv_bad = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_program_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_we      (imem_we),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  // Write capture plus always-true relations between the status outputs.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
    if (reset_n === 1'b1 &&
        (rx_ready !== busy || cpu_hold !== ~done || imem_addr[1:0] !== 2'b00 || (done && error)))
      inv_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    for (int g = 0; g < 8 && !ok; g++) begin
      @(negedge clock);
      if (rx_ready === 1'b1) ok = 1'b1;
      @(posedge clock); #1;
    end
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle per byte, 2 random 0..3 idle cycles
  task automatic send_stream(input byte_q_t b, input int gap_mode, input int start_at);
    int gap;
    foreach (b[i]) begin
      gap   = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(3, 0)) : 0;
      start = (i == start_at);
      send_byte(b[i], gap);
      start = 1'b0;
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1 || error === 1'b1) seen = 1'b1;
    end
    check({tag, "_ended"}, 32'(seen), 32'd1);
  endtask

  // Expected writes follow directly from the stream: word i at BASE+4i, bytes 2+4i.. big-endian.
  task automatic check_load(input string tag, input byte_q_t b);
    int len;
    logic [31:0] exp_d;
    len = int'({b[0], b[1]});
    wait_end(tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'(len));
    check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(len));
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      exp_d = {b[2 + 4*i], b[3 + 4*i], b[4 + 4*i], b[5 + 4*i]};
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_d);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_addr"}, imem_addr, BASE);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    byte_q_t bq;
    bit      seen;
    int      len;

    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("rst");
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    check_reset_vals("idle");

    // Two words, rx_valid held high
    clear_writes();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    bq = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    send_stream(bq, 0, -1);
    check_load("two", bq);

    // Same stream, throttled; restart from DONE raises cpu_hold at the start edge
    clear_writes();
    pulse_start();
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_words", 32'(words_loaded), 32'd0);
    send_stream(bq, 1, -1);
    check_load("thr", bq);

    // Zero length
    clear_writes();
    pulse_start();
    bq = '{8'h00, 8'h00};
    send_stream(bq, 0, -1);
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen = 1'b1;
    end
    check("zero_done", 32'(seen), 32'd1);
    check("zero_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("zero_words", 32'(words_loaded), 32'd0);

    // Oversize header
    clear_writes();
    pulse_start();
    bq = '{8'h00, 8'h05};
    send_stream(bq, 0, -1);
    wait_end("over");
    check("over_error", 32'(error), 32'd1);
    check("over_done", 32'(done), 32'd0);
    check("over_hold", 32'(cpu_hold), 32'd1);
    check("over_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Timeout with a partial word pending, then recovery
    clear_writes();
    pulse_start();
    check("err_cleared", 32'(error), 32'd0);
    bq = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_stream(bq, 0, -1);
    repeat (TMO) @(negedge clock);
    check("tmo_early", 32'(error), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clock);
      if (error === 1'b1) seen = 1'b1;
    end
    check("tmo_error", 32'(seen), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_nwr", 32'(wr_addr_q.size()), 32'd0);
    clear_writes();
    pulse_start();
    check("tmo_restart_err", 32'(error), 32'd0);
    bq = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_stream(bq, 0, -1);
    check_load("tmo_reload", bq);

    // Reset in the middle of the first word
    clear_writes();
    pulse_start();
    bq = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
    send_stream(bq, 0, -1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_ready", 32'(rx_ready), 32'd0);
    check("midrst_idle_hold", 32'(cpu_hold), 32'd1);
    check("midrst_nwr", 32'(wr_addr_q.size()), 32'd0);

    // Randomized loads with random throttling and a start pulse while busy
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(MAXW, 1));
      bq.delete();
      bq.push_back(8'(len >> 8));
      bq.push_back(8'(len));
      for (int k = 0; k < 4 * len; k++) bq.push_back(8'($urandom));
      clear_writes();
      pulse_start();
      send_stream(bq, 2, 4);
      check_load($sformatf("rnd%0d", it), bq);
    end

    check("invariants", 32'(inv_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
